// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, ALU select indices, IR field positions and sequencer states
package cpu_pkg;

    // IR field positions
    localparam int OPC_LSB = 27;
    localparam int RA_LSB  = 23;
    localparam int RB_LSB  = 19;
    localparam int RC_LSB  = 15;

    // Opcodes
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // alu_op one-hot bit indices
    localparam int ALU_W    = 13;
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_AND  = 2;
    localparam int ALU_OR   = 3;
    localparam int ALU_SHR  = 4;
    localparam int ALU_SHRA = 5;
    localparam int ALU_SHL  = 6;
    localparam int ALU_ROR  = 7;
    localparam int ALU_ROL  = 8;
    localparam int ALU_MUL  = 9;
    localparam int ALU_DIV  = 10;
    localparam int ALU_NEG  = 11;
    localparam int ALU_NOT  = 12;

    typedef enum logic [3:0] {
        ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALTED, ST_FAULT
    } state_e;

    // Instruction classes share an execute micro-sequence
    typedef enum logic [2:0] {
        CL_ALU2, CL_MULDIV, CL_UNARY, CL_NOP, CL_HALT, CL_ILLEGAL
    } op_class_e;

    function automatic op_class_e op_class(input logic [4:0] opc);
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL: return CL_ALU2;
            OP_MUL, OP_DIV:                  return CL_MULDIV;
            OP_NEG, OP_NOT:                  return CL_UNARY;
            OP_NOP:                          return CL_NOP;
            OP_HALT:                         return CL_HALT;
            default:                         return CL_ILLEGAL;
        endcase
    endfunction

    function automatic logic [ALU_W-1:0] alu_onehot(input logic [4:0] opc);
        logic [ALU_W-1:0] v;
        v = '0;
        case (opc)
            OP_ADD:  v[ALU_ADD]  = 1'b1;
            OP_SUB:  v[ALU_SUB]  = 1'b1;
            OP_AND:  v[ALU_AND]  = 1'b1;
            OP_OR:   v[ALU_OR]   = 1'b1;
            OP_SHR:  v[ALU_SHR]  = 1'b1;
            OP_SHRA: v[ALU_SHRA] = 1'b1;
            OP_SHL:  v[ALU_SHL]  = 1'b1;
            OP_ROR:  v[ALU_ROR]  = 1'b1;
            OP_ROL:  v[ALU_ROL]  = 1'b1;
            OP_MUL:  v[ALU_MUL]  = 1'b1;
            OP_DIV:  v[ALU_DIV]  = 1'b1;
            OP_NEG:  v[ALU_NEG]  = 1'b1;
            OP_NOT:  v[ALU_NOT]  = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// rtl/reg_field_decoder.sv - 4-to-16 one-hot register select decoder with enable
module reg_field_decoder (
    input  logic        en_i,
    input  logic [3:0]  sel_i,
    output logic [15:0] onehot_o
);

    // Single bit set for the selected register, nothing when disabled
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - fetch/execute control sequencer for the 32-bit bus datapath
module datapath_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] ir,
    input  logic        mem_rdy,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        ZHIin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [12:0] alu_op,
    output logic        running,
    output logic        fault,
    output logic        illegal
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_LIMIT - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       stop_q, stop_d;
    logic       stop_pend;
    logic [4:0] opc;
    logic [3:0] ra, rb, rc;
    op_class_e  cls;
    logic       rin_en, rout_en, alu_en;
    logic [3:0] rin_sel, rout_sel;
    logic       unused_ir;

    assign opc       = ir[OPC_LSB +: 5];
    assign ra        = ir[RA_LSB +: 4];
    assign rb        = ir[RB_LSB +: 4];
    assign rc        = ir[RC_LSB +: 4];
    assign cls       = op_class(opc);
    assign stop_pend = stop_q | stop;
    assign unused_ir = ^ir[RC_LSB-1:0];

    // Next state: fetch handshake with timeout, class-driven execute, stop honoured at instruction end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stop_d  = stop_pend;
        case (state_q)
            ST_IDLE, ST_HALTED, ST_FAULT: begin
                stop_d = start & stop;
                if (start) state_d = ST_T0;
            end
            ST_T0: state_d = ST_T1;
            ST_T1: begin
                if (mem_rdy) begin
                    state_d = ST_T2;
                    cnt_d   = '0;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = ST_FAULT;
                    cnt_d   = '0;
                    stop_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_T2: state_d = ST_T3;
            ST_T3: begin
                if (cls == CL_ALU2 || cls == CL_MULDIV || cls == CL_UNARY) begin
                    state_d = ST_T4;
                end else if (cls == CL_HALT) begin
                    state_d = ST_HALTED;
                    stop_d  = 1'b0;
                end else begin
                    state_d = stop_pend ? ST_IDLE : ST_T0;
                    stop_d  = 1'b0;
                end
            end
            ST_T4: begin
                if (cls == CL_UNARY) begin
                    state_d = stop_pend ? ST_IDLE : ST_T0;
                    stop_d  = 1'b0;
                end else begin
                    state_d = ST_T5;
                end
            end
            ST_T5: begin
                if (cls == CL_MULDIV) begin
                    state_d = ST_T6;
                end else begin
                    state_d = stop_pend ? ST_IDLE : ST_T0;
                    stop_d  = 1'b0;
                end
            end
            ST_T6: begin
                state_d = stop_pend ? ST_IDLE : ST_T0;
                stop_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, wait counter and sticky stop flag
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
        end
    end

    // Moore strobe decode from current state and instruction class
    always_comb begin
        {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin} = '0;
        {Yin, Zin, ZHIin, Zlowout, Zhighout, HIin, LOin}       = '0;
        rin_en   = 1'b0;
        rin_sel  = ra;
        rout_en  = 1'b0;
        rout_sel = rb;
        alu_en   = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            ST_T0: {PCout, MARin, IncPC, Zin} = 4'b1111;
            ST_T1: {Zlowout, PCin, Read, MDRin} = 4'b1111;
            ST_T2: {MDRout, IRin} = 2'b11;
            ST_T3: begin
                case (cls)
                    CL_ALU2:    begin rout_en = 1'b1; Yin = 1'b1; end
                    CL_MULDIV:  begin rout_en = 1'b1; rout_sel = ra; Yin = 1'b1; end
                    CL_UNARY:   begin rout_en = 1'b1; alu_en = 1'b1; Zin = 1'b1; end
                    CL_ILLEGAL: illegal = 1'b1;
                    default:    ;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CL_ALU2:   begin rout_en = 1'b1; rout_sel = rc; alu_en = 1'b1; Zin = 1'b1; end
                    CL_MULDIV: begin rout_en = 1'b1; alu_en = 1'b1; Zin = 1'b1; ZHIin = 1'b1; end
                    CL_UNARY:  begin Zlowout = 1'b1; rin_en = 1'b1; end
                    default:   ;
                endcase
            end
            ST_T5: begin
                case (cls)
                    CL_ALU2:   begin Zlowout = 1'b1; rin_en = 1'b1; end
                    CL_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; end
                    default:   ;
                endcase
            end
            ST_T6: begin
                if (cls == CL_MULDIV) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign alu_op  = alu_en ? alu_onehot(opc) : '0;
    assign running = !(state_q == ST_IDLE || state_q == ST_HALTED || state_q == ST_FAULT);
    assign fault   = (state_q == ST_FAULT);

    reg_field_decoder u_rin_dec (
        .en_i     (rin_en),
        .sel_i    (rin_sel),
        .onehot_o (Rin)
    );

    reg_field_decoder u_rout_dec (
        .en_i     (rout_en),
        .sel_i    (rout_sel),
        .onehot_o (Rout)
    );

endmodule
